zif_pin_ctrl: RTL and testbench
===============================

Name: zif_pin_ctrl

Overview:
- Per-pin driver/capture controller for the CPLD on the next-generation ZIF test shield.
- Replaces the fixed one-Arduino-pin-per-ZIF-pin wiring with a serial-configured bank of NPINS tristate pins.
- The host Arduino loads output-enable and output-data vectors and reads back pin states over a 4-wire serial link.
- Pin updates are double-buffered and applied atomically, so the device under test never sees a partially written vector.

Parameters:
- NPINS, 40: number of ZIF pins controlled (8..64).
- SYNC_STAGES, 2: synchroniser depth on sck, ss_n, mosi and pin_in.

Ports:
- clk  in  1  system clock; must be at least 8x the sck frequency.
- reset  in  1  synchronous, active-high.
- sck  in  1  serial clock from host; SPI mode 0.
- ss_n  in  1  frame select, active-low.
- mosi  in  1  serial data from host.
- miso  out  1  serial data to host.
- miso_oe  out  1  miso tristate enable; high while ss_n is low.
- pin_in  in  NPINS  ZIF pin input buffers.
- pin_oe  out  NPINS  per-pin output enable; 1 = drive.
- pin_out  out  NPINS  per-pin output value.
- err  out  1  sticky frame-error flag.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (synchronous, active-high; clk and reset are the only clock/reset ports):
  - pin_oe = 0 (all pins hi-Z), pin_out = 0, shadow registers = 0.
  - miso = 0, miso_oe = 0, err = 0, busy = 0, FSM = IDLE.
  - Reset asserted mid-frame aborts the frame. Nothing is committed.
- Input synchronisation: sck, ss_n and mosi each pass through SYNC_STAGES flops. The module derives sck_rise, sck_fall, ss_fall and ss_rise from the synchronised signals.
- Frame format, MSB first:
  - 8-bit opcode, then a payload of NPINS bits.
  - mosi is sampled on sck_rise.
  - miso updates on sck_fall.
- Opcodes:
  - 0x01 WR_OE: payload goes to shadow_oe.
  - 0x02 WR_DATA: payload goes to shadow_out.
  - 0x03 RD_PINS: the pins are captured; the payload is ignored.
  - 0x04 APPLY: 0-bit payload; commits both shadows.
  - 0x0F SAFE: 0-bit payload; clears pin_oe and shadow_oe.
  - Any other opcode is invalid.
- FSM states and transitions:
  - IDLE: on ss_fall go to OPCODE. Clear bit counter; busy = 1; miso_oe = 1.
  - OPCODE: shift in 8 bits. After the 8th sck_rise, decode the opcode:
    - WR_OE or WR_DATA: go to PAYLOAD.
    - RD_PINS: pin_snap <= synchronised pin_in on that cycle; go to PAYLOAD.
    - APPLY or SAFE: go to WAIT_END.
    - Invalid opcode: go to DISCARD.
  - PAYLOAD:
    - Count NPINS sck_rise events.
    - Write opcodes shift mosi into a staging register.
    - RD_PINS drives pin_snap onto miso MSB-first. The first bit appears at the sck_fall following the 8th opcode bit.
    - After NPINS bits, go to WAIT_END.
  - WAIT_END: any further sck_rise sets err and moves to DISCARD.
  - DISCARD: absorb all bits; nothing is committed.
- Commit on ss_rise (acted on only from WAIT_END):
  - WR_OE: staging -> shadow_oe.
  - WR_DATA: staging -> shadow_out.
  - APPLY: pin_oe <= shadow_oe and pin_out <= shadow_out in the same clk cycle. Latency from ss_rise is 1 clk.
  - SAFE: pin_oe <= 0 and shadow_oe <= 0 in the same single cycle.
- Abort rules:
  - ss_rise in OPCODE or PAYLOAD (short frame): set err, commit nothing.
  - ss_rise in DISCARD: commit nothing; err is set only if it is not already set.
  - Every ss_rise returns the FSM to IDLE with busy = 0, miso_oe = 0, miso = 0.
- err is sticky. It is cleared only by reset or by a complete, valid APPLY frame.
- Simultaneous events:
  - If sck_rise and ss_rise occur in the same clk cycle, the bit is processed first, then the end of frame.
  - If ss_fall occurs while the FSM is not IDLE (no ss_rise was seen), the FSM restarts at OPCODE.
- Widths:
  - Bit counter is $clog2(NPINS+1) bits and saturates at NPINS.
  - Opcode counter is 3 bits plus a done flag.

Decomposition:
- Package zif_pkg holds:
  - opcode constants OP_WR_OE, OP_WR_DATA, OP_RD_PINS, OP_APPLY, OP_SAFE;
  - state typedef zif_state_t (IDLE, OPCODE, PAYLOAD, WAIT_END, DISCARD);
  - the NPINS default.
- Sub-module zif_sync_edge: a SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated for sck and ss_n. mosi and pin_in use plain synchronisers.

Test Plan:
- Reset with pin_in random: pin_oe = 0, pin_out = 0, err = 0, miso_oe = 0.
- WR_OE 0x00000000FF, WR_DATA 0xA5A5A5A5A5, then APPLY: pin_oe/pin_out stay unchanged until 1 clk after the APPLY ss_rise, then become 0x00000000FF and 0xA5A5A5A5A5 together.
- pin_in = 0x123456789A, then RD_PINS: miso returns 0x123456789A MSB-first. Changing pin_in to 0 after the opcode does not change the returned data.
- WR_DATA with 39 payload bits, then APPLY: err = 1 and shadow_out is unchanged. The following APPLY commits the old shadow and clears err.
- Opcode 0x55 with 40 bits: err = 1, no register changes. Opcode WR_OE with 41 bits: err = 1, shadow_oe unchanged.
- After APPLY with oe = all ones, send SAFE: pin_oe = 0 one clk after ss_rise. A subsequent APPLY keeps pin_oe = 0. Reset mid-payload leaves pin_oe = 0 and the FSM in IDLE.

Source files
------------

// File: rtl/zif_pkg.sv
// Shared definitions for the ZIF pin controller: opcode values, FSM state
// type and the default pin count.
package zif_pkg;

   localparam int NPINS_DEF = 40;

   localparam logic [7:0] OP_WR_OE   = 8'h01;
   localparam logic [7:0] OP_WR_DATA = 8'h02;
   localparam logic [7:0] OP_RD_PINS = 8'h03;
   localparam logic [7:0] OP_APPLY   = 8'h04;
   localparam logic [7:0] OP_SAFE    = 8'h0F;

   typedef enum logic [2:0] {
      IDLE,
      OPCODE,
      PAYLOAD,
      WAIT_END,
      DISCARD
   } zif_state_t;

endpackage

// File: rtl/zif_sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   d            asynchronous input
//   rise, fall   one-clk pulses on a synchronised 0->1 / 1->0 transition
// RST_VAL is the idle level of the input, so releasing reset while the
// input rests at that level produces no spurious edge.
module zif_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] pipe;
   logic              prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe <= {STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         pipe <= {pipe[STAGES-2:0], d};
         prev <= pipe[STAGES-1];
      end
   end

   assign rise =  pipe[STAGES-1] & ~prev;
   assign fall = ~pipe[STAGES-1] &  prev;

endmodule

// File: rtl/zif_pin_ctrl.sv
// Serial-configured tristate controller for a bank of ZIF pins.
// The host shifts an 8-bit opcode plus payload in SPI mode 0; write data is
// staged and only reaches the pins through an APPLY frame, so the pins are
// always updated as a whole vector.
// Ports:
//   clk, reset          system clock (>= 8x sck), synchronous active-high reset
//   sck, ss_n, mosi     serial link from host (asynchronous to clk)
//   miso, miso_oe       serial data to host and its tristate enable
//   pin_in              pin input buffers
//   pin_oe, pin_out     per-pin drive enable and drive value
//   err                 sticky frame error
//   busy                frame in progress
//
// state    | meaning
// IDLE     | no frame open
// OPCODE   | shifting in the 8 opcode bits
// PAYLOAD  | shifting NPINS payload bits (write) or shifting out pin_snap (read)
// WAIT_END | frame complete, waiting for ss_n to rise to commit
// DISCARD  | bad frame, absorb bits until ss_n rises
module zif_pin_ctrl
   import zif_pkg::*;
#(
   parameter int NPINS       = NPINS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sck,
   input  logic             ss_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [NPINS-1:0] pin_in,
   output logic [NPINS-1:0] pin_oe,
   output logic [NPINS-1:0] pin_out,
   output logic             err,
   output logic             busy
);

   localparam int CW = $clog2(NPINS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NPINS - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(NPINS);

   logic sck_rise, sck_fall, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0]            mosi_pipe;
   logic [SYNC_STAGES-1:0][NPINS-1:0] pin_pipe;
   logic                              mosi_s;
   logic [NPINS-1:0]                  pin_s;

   zif_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .reset(reset), .d(sck), .rise(sck_rise), .fall(sck_fall)
   );

   zif_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .reset(reset), .d(ss_n), .rise(ss_rise), .fall(ss_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mosi_pipe <= '0;
         pin_pipe  <= '0;
      end else begin
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
         pin_pipe  <= {pin_pipe[SYNC_STAGES-2:0], pin_in};
      end
   end

   assign mosi_s = mosi_pipe[SYNC_STAGES-1];
   assign pin_s  = pin_pipe[SYNC_STAGES-1];

   zif_state_t       state, st_b;
   logic [7:0]       op_sr, op_b;
   logic [2:0]       op_cnt, op_cnt_b;
   logic [CW-1:0]    bit_cnt, bit_cnt_b;
   logic [NPINS-1:0] staging, stage_b;
   logic [NPINS-1:0] pin_snap;
   logic [NPINS-1:0] shadow_oe, shadow_out;
   logic             err_b, snap_load;

   // Effect of this cycle's sck_rise alone. The frame-end logic below works
   // from these values, so a bit landing in the same cycle as ss_rise is
   // absorbed before the commit decision.
   always_comb begin
      st_b      = state;
      op_b      = op_sr;
      op_cnt_b  = op_cnt;
      bit_cnt_b = bit_cnt;
      stage_b   = staging;
      err_b     = err;
      snap_load = 1'b0;
      if (sck_rise) begin
         case (state)
            OPCODE: begin
               op_b     = {op_sr[6:0], mosi_s};
               op_cnt_b = op_cnt + 3'd1;
               if (op_cnt == 3'd7) begin
                  bit_cnt_b = '0;
                  case (op_b)
                     OP_WR_OE, OP_WR_DATA: st_b = PAYLOAD;
                     OP_RD_PINS: begin
                        st_b      = PAYLOAD;
                        snap_load = 1'b1;
                     end
                     OP_APPLY, OP_SAFE: st_b = WAIT_END;
                     default: st_b = DISCARD;
                  endcase
               end
            end
            PAYLOAD: begin
               stage_b = {staging[NPINS-2:0], mosi_s};
               if (bit_cnt != CNT_MAX) bit_cnt_b = bit_cnt + CW'(1);
               if (bit_cnt == CNT_LAST) st_b = WAIT_END;
            end
            WAIT_END: begin
               err_b = 1'b1;
               st_b  = DISCARD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_sr      <= '0;
         op_cnt     <= '0;
         bit_cnt    <= '0;
         staging    <= '0;
         pin_snap   <= '0;
         shadow_oe  <= '0;
         shadow_out <= '0;
         pin_oe     <= '0;
         pin_out    <= '0;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else if (ss_fall) begin
         // Also restarts a frame whose ss_rise was never seen.
         state   <= OPCODE;
         op_cnt  <= '0;
         bit_cnt <= '0;
         busy    <= 1'b1;
         miso_oe <= 1'b1;
         miso    <= 1'b0;
      end else if (ss_rise) begin
         state   <= IDLE;
         op_cnt  <= '0;
         bit_cnt <= '0;
         busy    <= 1'b0;
         miso_oe <= 1'b0;
         miso    <= 1'b0;
         err     <= err_b;
         case (st_b)
            OPCODE, PAYLOAD, DISCARD: err <= 1'b1;
            WAIT_END: begin
               case (op_b)
                  OP_WR_OE:   shadow_oe  <= stage_b;
                  OP_WR_DATA: shadow_out <= stage_b;
                  OP_APPLY: begin
                     pin_oe  <= shadow_oe;
                     pin_out <= shadow_out;
                     err     <= 1'b0;
                  end
                  OP_SAFE: begin
                     pin_oe    <= '0;
                     shadow_oe <= '0;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end else begin
         state   <= st_b;
         op_sr   <= op_b;
         op_cnt  <= op_cnt_b;
         bit_cnt <= bit_cnt_b;
         staging <= stage_b;
         err     <= err_b;
         if (snap_load) begin
            pin_snap <= pin_s;
         end else if (sck_fall && state == PAYLOAD && op_sr == OP_RD_PINS) begin
            miso     <= pin_snap[NPINS-1];
            pin_snap <= {pin_snap[NPINS-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_zif_pin_ctrl.sv
// Bench for zif_pin_ctrl: directed frames followed by random frames, all
// checked against a frame-level model of the pin controller.
module tb_zif_pin_ctrl;

   localparam int NPINS = 40;
   localparam int SYNC  = 2;
   localparam int HALF  = 6;

   localparam logic [7:0] C_WR_OE   = 8'h01;
   localparam logic [7:0] C_WR_DATA = 8'h02;
   localparam logic [7:0] C_RD_PINS = 8'h03;
   localparam logic [7:0] C_APPLY   = 8'h04;
   localparam logic [7:0] C_SAFE    = 8'h0F;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             sck = 1'b0;
   logic             ss_n = 1'b1;
   logic             mosi = 1'b0;
   logic             miso, miso_oe, err, busy;
   logic [NPINS-1:0] pin_in = '0;
   logic [NPINS-1:0] pin_oe, pin_out;

   int checks = 0;
   int errors = 0;

   logic [NPINS-1:0] m_soe, m_sout, m_oe, m_out;
   logic             m_err;

   zif_pin_ctrl #(.NPINS(NPINS), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .pin_in(pin_in), .pin_oe(pin_oe),
      .pin_out(pin_out), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      m_soe  = '0;
      m_sout = '0;
      m_oe   = '0;
      m_out  = '0;
      m_err  = 1'b0;
   endtask

   // A frame commits only if it has a known opcode and exactly the right
   // number of bits; anything else just raises err.
   task automatic model_frame(input logic [7:0] op, input int nbits, input logic [NPINS-1:0] pl);
      int  plen;
      bit  known;
      known = (op == C_WR_OE) || (op == C_WR_DATA) || (op == C_RD_PINS) ||
              (op == C_APPLY) || (op == C_SAFE);
      plen  = ((op == C_WR_OE) || (op == C_WR_DATA) || (op == C_RD_PINS)) ? NPINS : 0;
      if (!known || nbits != 8 + plen) begin
         m_err = 1'b1;
      end else begin
         case (op)
            C_WR_OE:   m_soe  = pl;
            C_WR_DATA: m_sout = pl;
            C_APPLY: begin
               m_oe  = m_soe;
               m_out = m_sout;
               m_err = 1'b0;
            end
            C_SAFE: begin
               m_oe  = '0;
               m_soe = '0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ss_n  = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      clks(4);
      reset = 1'b0;
      clks(SYNC + 2);
      model_reset();
   endtask

   task automatic send_frame(input logic [7:0] op, input int nbits, input logic [NPINS-1:0] pl,
                             input bit zero_pins, input int abort_at,
                             output logic [NPINS-1:0] rx);
      logic [NPINS-1:0] old_oe, old_out, snap;
      old_oe  = m_oe;
      old_out = m_out;
      snap    = pin_in;
      rx      = '0;
      ss_n    = 1'b0;
      clks(HALF);
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_at) begin
            reset = 1'b1;
            clks(2);
            ss_n = 1'b1;
            sck  = 1'b0;
            clks(2);
            reset = 1'b0;
            clks(SYNC + 2);
            model_reset();
            check_val("abort_busy", 64'(busy), 64'd0);
            check_val("abort_oe", 64'(pin_oe), 64'd0);
            check_val("abort_err", 64'(err), 64'd0);
            check_val("abort_miso_oe", 64'(miso_oe), 64'd0);
            return;
         end
         if (i < 8) mosi = op[7-i];
         else if (i - 8 < NPINS) mosi = pl[NPINS-1-(i-8)];
         else mosi = 1'($urandom_range(0, 1));
         clks(HALF);
         if (i == 0) begin
            check_val("frame_busy", 64'(busy), 64'd1);
            check_val("frame_miso_oe", 64'(miso_oe), 64'd1);
         end
         if (i >= 8 && i - 8 < NPINS) rx[NPINS-1-(i-8)] = miso;
         sck = 1'b1;
         clks(HALF);
         sck = 1'b0;
         if (i == 7 && zero_pins) pin_in = '0;
      end
      clks(HALF);
      ss_n = 1'b1;
      model_frame(op, nbits, pl);
      clks(SYNC);
      check_val("pre_oe", 64'(pin_oe), 64'(old_oe));
      check_val("pre_out", 64'(pin_out), 64'(old_out));
      clks(1);
      check_val("pin_oe", 64'(pin_oe), 64'(m_oe));
      check_val("pin_out", 64'(pin_out), 64'(m_out));
      check_val("err", 64'(err), 64'(m_err));
      check_val("end_busy", 64'(busy), 64'd0);
      check_val("end_miso_oe", 64'(miso_oe), 64'd0);
      check_val("end_miso", 64'(miso), 64'd0);
      if (op == C_RD_PINS && nbits >= 8 + NPINS) check_val("rd_data", 64'(rx), 64'(snap));
      clks(HALF);
   endtask

   initial begin
      logic [NPINS-1:0] rx, pl;
      logic [7:0]       op;
      int               sel, nb, plen;

      pin_in = NPINS'({$urandom(), $urandom()});
      do_reset();
      check_val("rst_oe", 64'(pin_oe), 64'd0);
      check_val("rst_out", 64'(pin_out), 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_miso_oe", 64'(miso_oe), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_miso", 64'(miso), 64'd0);

      send_frame(C_WR_OE, 8 + NPINS, 40'h00000000FF, 1'b0, -1, rx);
      send_frame(C_WR_DATA, 8 + NPINS, 40'hA5A5A5A5A5, 1'b0, -1, rx);
      send_frame(C_APPLY, 8, '0, 1'b0, -1, rx);
      check_val("apply_oe", 64'(pin_oe), 64'h00000000FF);
      check_val("apply_out", 64'(pin_out), 64'hA5A5A5A5A5);

      pin_in = 40'h123456789A;
      send_frame(C_RD_PINS, 8 + NPINS, NPINS'({$urandom(), $urandom()}), 1'b1, -1, rx);
      check_val("rd_const", 64'(rx), 64'h123456789A);

      send_frame(C_WR_DATA, 8 + NPINS - 1, 40'h0F0F0F0F0F, 1'b0, -1, rx);
      check_val("short_err", 64'(err), 64'd1);
      send_frame(C_APPLY, 8, '0, 1'b0, -1, rx);
      check_val("short_keep_out", 64'(pin_out), 64'hA5A5A5A5A5);
      check_val("short_err_clr", 64'(err), 64'd0);

      send_frame(8'h55, 8 + NPINS, 40'hFFFFFFFFFF, 1'b0, -1, rx);
      check_val("badop_err", 64'(err), 64'd1);
      send_frame(C_WR_OE, 8 + NPINS + 1, 40'h3C3C3C3C3C, 1'b0, -1, rx);
      check_val("long_err", 64'(err), 64'd1);
      send_frame(C_APPLY, 8, '0, 1'b0, -1, rx);
      check_val("long_keep_oe", 64'(pin_oe), 64'h00000000FF);

      send_frame(C_WR_OE, 8 + NPINS, '1, 1'b0, -1, rx);
      send_frame(C_APPLY, 8, '0, 1'b0, -1, rx);
      check_val("all_oe", 64'(pin_oe), 64'hFFFFFFFFFF);
      send_frame(C_SAFE, 8, '0, 1'b0, -1, rx);
      check_val("safe_oe", 64'(pin_oe), 64'd0);
      send_frame(C_APPLY, 8, '0, 1'b0, -1, rx);
      check_val("safe_apply_oe", 64'(pin_oe), 64'd0);

      send_frame(C_WR_OE, 8 + NPINS, 40'hFFFF0000FF, 1'b0, 20, rx);
      send_frame(C_APPLY, 8, '0, 1'b0, -1, rx);

      for (int n = 0; n < 30; n++) begin
         sel = $urandom_range(0, 6);
         case (sel)
            0: op = C_WR_OE;
            1: op = C_WR_DATA;
            2: op = C_RD_PINS;
            3, 4: op = C_APPLY;
            5: op = C_SAFE;
            default: op = 8'($urandom_range(16, 255));
         endcase
         plen = (sel <= 2) ? NPINS : ((sel == 6) ? $urandom_range(0, NPINS) : 0);
         nb = 8 + plen;
         if ($urandom_range(0, 4) == 0) nb = ($urandom_range(0, 1) == 1) ? nb + 1 : nb - 1;
         pin_in = NPINS'({$urandom(), $urandom()});
         pl     = NPINS'({$urandom(), $urandom()});
         send_frame(op, nb, pl, 1'($urandom_range(0, 1)), -1, rx);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
